// File: rtl/tm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tm_pkg
// Purpose  : Shared types and constants for the single-tape Turing-machine
//            step controller: FSM state encoding, rule-memory entry layout,
//            machine-state and rule widths.
// Revision : 1.0 - initial release
// ============================================================================
package tm_pkg;

  localparam int STATE_W = 3;   // width of the machine (rule) state
  localparam int RULE_W  = 8;   // width of one rule-memory entry
  localparam int FSM_W   = 3;   // width of the controller FSM encoding

  typedef enum logic [FSM_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERROR = 3'd5
  } tm_fsm_e;

  // Rule-memory entry, MSB first: valid, next_state, write_sym, move_left,
  // halt, and one reserved bit that the controller never interprets.
  typedef struct packed {
    logic               valid;
    logic [STATE_W-1:0] next_state;
    logic               write_sym;
    logic               move_left;
    logic               halt;
    logic               rsvd;
  } rule_t;

endpackage
`default_nettype wire

// File: rtl/tm_tape.sv
`default_nettype none
// ============================================================================
// Module   : tm_tape
// Purpose  : One-bit-per-cell tape storage with bulk load, head-indexed
//            write/read, and the head-move bounds check (no wrap-around).
// Ports    : clock, reset      - clock / async active-high reset (tape -> 0)
//            load, load_data   - bulk load of the whole tape
//            wr_en, wr_bit     - write wr_bit into the cell under head
//            head, move_left   - current head and requested move direction
//            tape, rd_bit      - tape contents and the cell under head
//            head_moved        - head after the requested move
//            move_oob          - requested move would leave the tape
// Revision : 1.0 - initial release
// ============================================================================
module tm_tape #(
  parameter int TAPE_LEN = 16,
  parameter int HEAD_W   = $clog2(TAPE_LEN)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [TAPE_LEN-1:0] load_data,
  input  logic                wr_en,
  input  logic                wr_bit,
  input  logic [HEAD_W-1:0]   head,
  input  logic                move_left,
  output logic [TAPE_LEN-1:0] tape,
  output logic                rd_bit,
  output logic [HEAD_W-1:0]   head_moved,
  output logic                move_oob
);

  localparam logic [HEAD_W-1:0] c_head_last = HEAD_W'(TAPE_LEN - 1);
  localparam logic [HEAD_W-1:0] c_head_one  = HEAD_W'(1);

  logic [TAPE_LEN-1:0] r_tape;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tape <= '0;
    end else if (load) begin
      r_tape <= load_data;
    end else if (wr_en) begin
      r_tape[head] <= wr_bit;
    end
  end

  assign tape   = r_tape;
  assign rd_bit = r_tape[head];

  // "move_left" advances toward the higher cell index.
  assign head_moved = move_left ? (head + c_head_one) : (head - c_head_one);
  assign move_oob   = move_left ? (head == c_head_last) : (head == '0);

endmodule
`default_nettype wire

// File: rtl/tm_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tm_step_ctrl
// Purpose  : Step controller for a single-tape binary Turing machine driven
//            from an external combinational-read 16x8 rule memory. Each step
//            is FETCH (look up rule) + EXEC (write, move, change state), with
//            optional single-step pausing, halt and error detection.
// Ports    : clock, reset          - clock / async active-high reset
//            start                 - begin a run (IDLE/HALT/ERROR only)
//            step_mode, step       - pause after each step / resume one step
//            tape_load, tape_init  - load tape (IDLE/HALT/ERROR only)
//            rule_re, rule_addr    - rule-memory read strobe and address
//            rule_data             - rule-memory entry (see tm_pkg::rule_t)
//            tape, head, cur_state - machine state
//            busy, halted, error   - run status decoded from the FSM
//            step_count            - executed steps, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module tm_step_ctrl
  import tm_pkg::*;
#(
  parameter int TAPE_LEN  = 16,
  parameter int HEAD_INIT = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        step_mode,
  input  logic                        step,
  input  logic                        tape_load,
  input  logic [TAPE_LEN-1:0]         tape_init,
  output logic                        rule_re,
  output logic [3:0]                  rule_addr,
  input  logic [RULE_W-1:0]           rule_data,
  output logic [TAPE_LEN-1:0]         tape,
  output logic [$clog2(TAPE_LEN)-1:0] head,
  output logic [STATE_W-1:0]          cur_state,
  output logic                        busy,
  output logic                        halted,
  output logic                        error,
  output logic [7:0]                  step_count
);

  localparam int                HEAD_W      = $clog2(TAPE_LEN);
  localparam logic [HEAD_W-1:0] c_head_init = HEAD_W'(HEAD_INIT);
  localparam logic [7:0]        c_cnt_max   = 8'hFF;

  tm_fsm_e             r_state;
  tm_fsm_e             w_state_next;
  rule_t               r_rule;
  logic [HEAD_W-1:0]   r_head;
  logic [STATE_W-1:0]  r_cur_state;
  logic [7:0]          r_step_count;

  logic                w_rest;       // FSM is in a state that accepts start/load
  logic                w_start_run;
  logic                w_load;
  logic                w_exec_ok;    // EXEC with a valid rule: write + state update
  logic                w_rd_bit;
  logic [HEAD_W-1:0]   w_head_moved;
  logic                w_move_oob;
  logic                w_unused_rsvd;

  assign w_rest      = (r_state == ST_IDLE) || (r_state == ST_HALT) || (r_state == ST_ERROR);
  assign w_start_run = w_rest && start;
  assign w_load      = w_rest && tape_load;
  assign w_exec_ok   = (r_state == ST_EXEC) && r_rule.valid;

  assign w_unused_rsvd = r_rule.rsvd;

  tm_tape #(
    .TAPE_LEN (TAPE_LEN),
    .HEAD_W   (HEAD_W)
  ) u_tape (
    .clock      (clock),
    .reset      (reset),
    .load       (w_load),
    .load_data  (tape_init),
    .wr_en      (w_exec_ok),
    .wr_bit     (r_rule.write_sym),
    .head       (r_head),
    .move_left  (r_rule.move_left),
    .tape       (tape),
    .rd_bit     (w_rd_bit),
    .head_moved (w_head_moved),
    .move_oob   (w_move_oob)
  );

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    rule_re      = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    error        = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        halted = (r_state == ST_HALT);
        error  = (r_state == ST_ERROR);
        if (start) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rule_re      = 1'b1;
        busy         = 1'b1;
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (!r_rule.valid) begin
          w_state_next = ST_ERROR;
        end else if (r_rule.halt) begin
          w_state_next = ST_HALT;
        end else if (w_move_oob) begin
          w_state_next = ST_ERROR;
        end else if (step_mode) begin
          w_state_next = ST_PAUSE;
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_PAUSE: begin
        busy = 1'b1;
        if (step || !step_mode) begin
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Head, machine state, step counter and rule register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head       <= c_head_init;
      r_cur_state  <= '0;
      r_step_count <= '0;
      r_rule       <= '0;
    end else begin
      if (w_start_run) begin
        r_head       <= c_head_init;
        r_cur_state  <= '0;
        r_step_count <= '0;
      end
      if (r_state == ST_FETCH) begin
        r_rule <= rule_data;
      end
      if (w_exec_ok) begin
        r_cur_state <= r_rule.next_state;
        if (r_step_count != c_cnt_max) begin
          r_step_count <= r_step_count + 8'd1;
        end
        // Halting or an out-of-range move leaves the head where it is.
        if (!r_rule.halt && !w_move_oob) begin
          r_head <= w_head_moved;
        end
      end
    end
  end

  // The address is formed from registers, so it is already valid in FETCH
  // even when the tape was loaded on the same edge as start.
  assign rule_addr  = {r_cur_state, w_rd_bit};
  assign head       = r_head;
  assign cur_state  = r_cur_state;
  assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_tm_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm_step_ctrl
// Purpose  : Self-checking bench for tm_step_ctrl: a step-level behavioural
//            model plus directed scenarios and randomized runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm_step_ctrl;

  localparam int TAPE_LEN  = 16;
  localparam int HEAD_INIT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        tape_load = 1'b0;
  logic [15:0] tape_init = '0;
  logic        rule_re;
  logic [3:0]  rule_addr;
  logic [7:0]  rule_data;
  logic [15:0] tape;
  logic [3:0]  head;
  logic [2:0]  cur_state;
  logic        busy, halted, error;
  logic [7:0]  step_count;

  logic [7:0]  rom [16];
  assign rule_data = rom[rule_addr];

  tm_step_ctrl #(.TAPE_LEN(TAPE_LEN), .HEAD_INIT(HEAD_INIT)) dut (
    .clock(clock), .reset(reset), .start(start), .step_mode(step_mode),
    .step(step), .tape_load(tape_load), .tape_init(tape_init),
    .rule_re(rule_re), .rule_addr(rule_addr), .rule_data(rule_data),
    .tape(tape), .head(head), .cur_state(cur_state), .busy(busy),
    .halted(halted), .error(error), .step_count(step_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases of a run: waiting, about to look up a rule, applying a rule,
  // paused between steps, halted, errored.
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_PAUSE = 3, M_HALT = 4, M_ERROR = 5;
  int          m_ph;
  logic [15:0] m_tape;
  int          m_head;
  int          m_cs;
  int          m_cnt;
  int          m_nh;
  logic [7:0]  m_rule;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_ph = M_IDLE; m_tape = '0; m_head = HEAD_INIT; m_cs = 0; m_cnt = 0; m_rule = '0;
      end else begin
        case (m_ph)
          M_IDLE, M_HALT, M_ERROR: begin
            if (tape_load) m_tape = tape_init;
            if (start) begin
              m_cs = 0; m_head = HEAD_INIT; m_cnt = 0; m_ph = M_FETCH;
            end
          end
          M_FETCH: begin
            m_rule = rom[m_cs * 2 + int'(m_tape[m_head])];
            m_ph   = M_EXEC;
          end
          M_EXEC: begin
            if (!m_rule[7]) begin
              m_ph = M_ERROR;
            end else begin
              m_tape[m_head] = m_rule[3];
              m_cs  = int'(m_rule[6:4]);
              m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
              if (m_rule[1]) begin
                m_ph = M_HALT;
              end else begin
                m_nh = m_rule[2] ? m_head + 1 : m_head - 1;
                if (m_nh < 0 || m_nh > TAPE_LEN - 1) begin
                  m_ph = M_ERROR;
                end else begin
                  m_head = m_nh;
                  m_ph   = step_mode ? M_PAUSE : M_FETCH;
                end
              end
            end
          end
          M_PAUSE: if (step || !step_mode) m_ph = M_FETCH;
          default: m_ph = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("tape",       tape,       m_tape);
        chk("head",       head,       m_head);
        chk("cur_state",  cur_state,  m_cs);
        chk("step_count", step_count, m_cnt);
        chk("busy",   busy,   (m_ph == M_FETCH || m_ph == M_EXEC || m_ph == M_PAUSE));
        chk("halted", halted, (m_ph == M_HALT));
        chk("error",  error,  (m_ph == M_ERROR));
        chk("rule_re", rule_re, (m_ph == M_FETCH));
        if (m_ph == M_FETCH) chk("rule_addr", rule_addr, m_cs * 2 + int'(m_tape[m_head]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rom_fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic launch(input logic [15:0] ti, input logic ld);
    tape_init = ti;
    tape_load = ld;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    tape_load = 1'b0;
  endtask

  initial begin
    logic [7:0] rv;
    int         guard;
    rom_fill(8'h00);
    #1 reset = 1'b1;
    @(negedge clock);
    #1;
    chk("lit_rst_tape", tape, 16'h0000);
    chk("lit_rst_head", head, 4'd8);
    chk("lit_rst_busy", busy, 1'b0);
    chk("lit_rst_cnt",  step_count, 8'd0);
    chk("lit_rst_hlt_err", {halted, error}, 2'b00);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Two-step program ending in halt
    rom_fill(8'h00);
    rom[0] = 8'h98;   // {0,0}: valid, next 1, write 1, move toward lower index
    rom[2] = 8'h8A;   // {1,0}: valid, write 1, halt
    launch(16'h0000, 1'b1);
    repeat (4) tick();
    chk("lit_halt_halted", halted, 1'b1);
    chk("lit_halt_tape",   tape, 16'h0180);
    chk("lit_halt_head",   head, 4'd7);
    chk("lit_halt_cnt",    step_count, 8'd2);

    // Invalid first rule
    rom_fill(8'h00);
    launch(16'h0000, 1'b0);
    repeat (2) tick();
    chk("lit_inv_error", error, 1'b1);
    chk("lit_inv_tape",  tape, 16'h0180);
    chk("lit_inv_cnt",   step_count, 8'd0);

    // Run off the high end of the tape
    rom_fill(8'h00);
    rom[0] = 8'h8C;   // valid, next 0, write 1, move toward higher index
    launch(16'h0000, 1'b1);
    guard = 0;
    while (!error && guard < 100) begin
      tick();
      guard++;
    end
    chk("lit_oob_error", error, 1'b1);
    chk("lit_oob_head",  head, 4'd15);
    chk("lit_oob_tape",  tape, 16'hFF00);

    // Simultaneous start+load, then a start while busy
    rom_fill(8'h88);  // valid, next 0, write 1, move toward lower index
    launch(16'h0100, 1'b1);
    chk("lit_sl_re",   rule_re, 1'b1);
    chk("lit_sl_addr", rule_addr, 4'h1);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("lit_ign_head", head, 4'd6);
    chk("lit_ign_cnt",  step_count, 8'd2);
    do_reset();

    // Reset in the middle of EXEC
    tape_init = 16'hA5A5; tape_load = 1'b1;
    tick();
    tape_load = 1'b0;
    launch(16'h0000, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("lit_rmid_tape", tape, 16'h0000);
    chk("lit_rmid_head", head, 4'd8);
    chk("lit_rmid_busy", busy, 1'b0);

    // Single-step mode
    step_mode = 1'b1;
    launch(16'h0000, 1'b1);
    repeat (7) tick();
    chk("lit_pause_busy", busy, 1'b1);
    chk("lit_pause_cnt",  step_count, 8'd1);
    for (int k = 2; k <= 4; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (5) tick();
      chk("lit_step_cnt",  step_count, k);
      chk("lit_step_busy", busy, 1'b1);
    end
    step_mode = 1'b0;
    do_reset();

    // Endless oscillation to reach counter saturation
    rom_fill(8'h00);
    rom[0] = 8'h94;   // {0,0}: next 1, write 0, toward higher index
    rom[2] = 8'h80;   // {1,0}: next 0, write 0, toward lower index
    launch(16'h0000, 1'b1);
    repeat (600) tick();
    chk("lit_sat_cnt",  step_count, 8'd255);
    chk("lit_sat_busy", busy, 1'b1);
    do_reset();

    // Randomized runs
    for (int run = 0; run < 80; run++) begin
      for (int i = 0; i < 16; i++) begin
        rv    = 8'($urandom);
        rv[7] = ($urandom_range(0, 7) != 0);
        rv[1] = ($urandom_range(0, 5) == 0);
        rom[i] = rv;
      end
      step_mode = 1'($urandom);
      launch(16'($urandom), 1'($urandom));
      repeat (40) begin
        step      = ($urandom_range(0, 3) == 0);
        start     = ($urandom_range(0, 31) == 0);
        tape_load = ($urandom_range(0, 15) == 0);
        tape_init = 16'($urandom);
        if ($urandom_range(0, 7) == 0) step_mode = ~step_mode;
        reset     = ($urandom_range(0, 149) == 0);
        tick();
      end
      step = 1'b0; start = 1'b0; tape_load = 1'b0; reset = 1'b0;
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/tm_step_ctrl.md
TM_STEP_CTRL -- requirements
Module: tm_step_ctrl

Interface
REQ-001 SHALL have parameter TAPE_LEN, default 16, tape length in cells (1 bit per cell).
REQ-002 SHALL have parameter HEAD_INIT, default 8, head position at start of a run.
REQ-003 SHALL have ports: clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high; forces the state in REQ-027.
REQ-005 start  in  1  one-cycle pulse that begins a run.
REQ-006 step_mode  in  1  1 = pause after each executed step.
REQ-007 step  in  1  one-cycle pulse that advances one step while paused.
REQ-008 tape_load  in  1  loads tape_init into the tape.
REQ-009 tape_init  in  TAPE_LEN  initial tape contents.
REQ-010 rule_re  out  1  read enable to the rule memory (combinational-read, 16x8).
REQ-011 rule_addr  out  4  {cur_state[2:0], tape[head]}.
REQ-012 rule_data  in  8  entry: [7] valid, [6:4] next_state, [3] write_sym, [2] move_left, [1] halt, [0] ignored.
REQ-013 tape  out  TAPE_LEN; head  out  clog2(TAPE_LEN); cur_state  out  3.
REQ-014 busy  out  1; halted  out  1; error  out  1; step_count  out  8.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, EXEC, PAUSE, HALT, ERROR.
REQ-016 In IDLE/HALT/ERROR, tape_load SHALL copy tape_init into tape at the next edge; it SHALL be ignored in any other state.
REQ-017 In IDLE/HALT/ERROR, start SHALL set cur_state=0, head=HEAD_INIT, step_count=0, clear halted/error, and go to FETCH; start SHALL be ignored in any other state.
REQ-018 If start and tape_load occur in the same cycle, both SHALL take effect, and the first FETCH SHALL read the newly loaded tape.
REQ-019 FETCH SHALL assert rule_re=1 and drive rule_addr, latch rule_data into an internal rule register, and go to EXEC after exactly 1 cycle; rule_re SHALL be 0 in all other states.
REQ-020 In EXEC with valid=0: go to ERROR; tape, head and cur_state SHALL be unchanged.
REQ-021 In EXEC with valid=1: tape[head]<=write_sym, cur_state<=next_state, step_count increments and saturates at 255.
REQ-022 Then, if halt=1: go to HALT; the head SHALL not move.
REQ-023 Else, if move_left=1 the head SHALL go to head+1, otherwise to head-1; a move beyond TAPE_LEN-1 or below 0 SHALL not wrap: the head stays, the write still occurs, and the FSM goes to ERROR.
REQ-024 Else the FSM SHALL go to FETCH if step_mode=0, or to PAUSE if step_mode=1; one step therefore takes 2 cycles.
REQ-025 PAUSE SHALL go to FETCH on step, or on step_mode deasserting; start SHALL be ignored in PAUSE.
REQ-026 Outputs SHALL be: busy=1 in FETCH/EXEC/PAUSE; halted=1 only in HALT; error=1 only in ERROR; all outputs registered or decoded from state only.

Reset
REQ-027 Reset SHALL asynchronously force: FSM=IDLE, tape=0, head=HEAD_INIT, cur_state=0, step_count=0, rule register=0; busy/halted/error=0.
REQ-028 Reset mid-run SHALL abandon the step in progress with no partial tape write.

Structure
REQ-029 Package tm_pkg SHALL hold the FSM state enum, a packed rule_t struct for the REQ-012 layout, and the constants STATE_W=3 and RULE_W=8.
REQ-030 Tape storage with head-indexed write and bounds check SHALL be the sub-module tm_tape; the FSM, head, step counter and rule register live in tm_step_ctrl.

Verification
REQ-031 Reset mid-EXEC -> next cycle: tape=0, head=8, IDLE, busy=0.
REQ-032 Load tape_init=0; rule[{0,0}]=valid, next 1, write 1, right; rule[{1,0}]=valid, halt, write 1; start -> after 4 cycles: halted=1, tape[8]=1, tape[7]=1, head=7, step_count=2.
REQ-033 Rule for {0,0}=valid, move_left, loop to state 0; tape=0; start -> head reaches 15; the next step raises error=1 with head=15 and tape[15] written.
REQ-034 rule[{0,0}].valid=0; start -> error=1 after 2 cycles; tape unchanged; step_count=0.
REQ-035 step_mode=1 -> busy stays 1 in PAUSE with step_count unchanged until a step pulse; each pulse advances step_count by exactly 1.
REQ-036 start and tape_load asserted together with tape_init=16'h0100 -> first rule_addr={0,1}; start during busy is ignored.
